// File: rtl/oka_gf2_mul_seq.sv
// Sequential one-level Karatsuba carry-less multiplier on a digit-serial half core.
// Define OKA_REDUCE_EN to add the RED state, the POLY parameter and the y_red output.
module oka_gf2_mul_seq #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 8
`ifdef OKA_REDUCE_EN
  ,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(64'h1B)
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-2:0] y,
`ifdef OKA_REDUCE_EN
  output logic [WIDTH-1:0]   y_red,
`endif
  output logic               busy
);

  localparam int H  = WIDTH / 2;
  localparam int N  = H / DIGIT;
  localparam int ZW = 2 * H - 1;
  localparam int YW = 2 * WIDTH - 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || WIDTH % 2 != 0 || DIGIT < 1 || H % DIGIT != 0) begin : g_bad
    $error("oka_gf2_mul_seq: WIDTH must be even and WIDTH/2 a multiple of DIGIT");
  end

  typedef enum logic [2:0] {
    IDLE, MUL_Z0, MUL_Z1, MUL_Z2, COMB, RED, DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [H-1:0]     a_k, b_k;
  logic [DIGIT-1:0] dig;
  logic [ZW-1:0]    part, acc, acc_nxt;
  logic [ZW-1:0]    z0, z1, z2;
  logic [YW-1:0]    y_int, y_q;
  logic [CW-1:0]    cnt;
  logic             last;
  int               sh;

  assign last = (cnt == CW'(N - 1));
  assign y    = y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MUL_Z0;
      end
      MUL_Z0: if (last) state_nxt = MUL_Z1;
      MUL_Z1: if (last) state_nxt = MUL_Z2;
      MUL_Z2: if (last) state_nxt = COMB;
`ifdef OKA_REDUCE_EN
      COMB:   state_nxt = RED;
      RED:    state_nxt = DONE;
`else
      COMB:   state_nxt = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Half-product operands: z1 uses the folded halves
  always_comb begin
    a_k = '0;
    b_k = '0;
    unique case (1'b1)
      state == MUL_Z0: begin
        a_k = a_q[H-1:0];
        b_k = b_q[H-1:0];
      end
      state == MUL_Z1: begin
        a_k = a_q[H-1:0] ^ a_q[WIDTH-1:H];
        b_k = b_q[H-1:0] ^ b_q[WIDTH-1:H];
      end
      state == MUL_Z2: begin
        a_k = a_q[WIDTH-1:H];
        b_k = b_q[WIDTH-1:H];
      end
      default: ;
    endcase
  end

  always_comb begin
    sh   = DIGIT * int'(cnt);
    dig  = DIGIT'(b_k >> sh);
    part = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (dig[j]) part ^= ZW'(a_k) << j;
    end
    acc_nxt = ((cnt == '0) ? ZW'(0) : acc) ^ (part << sh);
  end

  always_comb begin
    y_int = YW'(z0)
          ^ (YW'(z0 ^ z1 ^ z2) << H)
          ^ (YW'(z2) << WIDTH);
  end

`ifdef OKA_REDUCE_EN
  logic [YW-1:0]    fold;
  logic [WIDTH-1:0] y_red_q;

  assign y_red = y_red_q;

  // Fold from the top bit down so earlier folds feed later ones
  always_comb begin
    fold = y_q;
    for (int i = YW - 1; i >= WIDTH; i--) begin
      if (fold[i]) fold ^= YW'({1'b1, POLY}) << (i - WIDTH);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
      z0  <= '0;
      z1  <= '0;
      z2  <= '0;
      y_q <= '0;
`ifdef OKA_REDUCE_EN
      y_red_q <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
          end
        end
        MUL_Z0, MUL_Z1, MUL_Z2: begin
          acc <= acc_nxt;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            if (state == MUL_Z0) z0 <= acc_nxt;
            if (state == MUL_Z1) z1 <= acc_nxt;
            if (state == MUL_Z2) z2 <= acc_nxt;
          end
        end
        COMB: y_q <= y_int;
`ifdef OKA_REDUCE_EN
        RED: y_red_q <= fold[WIDTH-1:0];
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oka_gf2_mul_seq.sv
// Scoreboard bench for oka_gf2_mul_seq: directed cases plus random traffic
// on 16/2, 64/8, 64/32 and 128/16 against a bit-serial clmul model.
module tb_oka_gf2_mul_seq;

  localparam int W  = 64;
  localparam int DG = 8;
  localparam int N  = W / 2 / DG;
`ifdef OKA_REDUCE_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif
  localparam int LAT = 3 * N + 2 + XL;

  typedef struct {
    logic [254:0] y;
    logic [127:0] r;
    int           t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [254:0] act,
                       input logic [254:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: schoolbook carry-less product, one multiplier bit at a time
  function automatic logic [254:0] clmul_ref(input logic [127:0] x,
                                             input logic [127:0] z,
                                             input int w);
    logic [254:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (z[i]) r ^= 255'(x) << i;
    end
    return r;
  endfunction

`ifdef OKA_REDUCE_EN
  // Field product by Horner over multiplier bits, x^w == 0x1B
  function automatic logic [127:0] mulmod_ref(input logic [127:0] x,
                                              input logic [127:0] z,
                                              input int w);
    logic [128:0] r;
    r = '0;
    for (int i = w - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[w]) begin
        r[w] = 1'b0;
        r ^= 129'h1B;
      end
      if (z[i]) r ^= {1'b0, x};
    end
    return r[127:0];
  endfunction
`endif

  function automatic logic [127:0] rnd(input int w);
    logic [127:0] v, m;
    v = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 9))
      0: v = '0;
      1: v = {128{1'b1}};
      default: ;
    endcase
    m = (w >= 128) ? {128{1'b1}} : ((128'(1) << w) - 128'(1));
    return v & m;
  endfunction

  function automatic exp_t mk_exp(input logic [127:0] x,
                                  input logic [127:0] z,
                                  input int w, input int t);
    exp_t e;
    e.y = clmul_ref(x, z, w);
`ifdef OKA_REDUCE_EN
    e.r = mulmod_ref(x, z, w);
`else
    e.r = '0;
`endif
    e.t = t;
    return e;
  endfunction

  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-2:0] y;
  logic           busy;
`ifdef OKA_REDUCE_EN
  logic [W-1:0]   y_red;
`endif

  oka_gf2_mul_seq #(.WIDTH(W), .DIGIT(DG)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y(y),
`ifdef OKA_REDUCE_EN
    .y_red(y_red),
`endif
    .busy(busy)
  );

  exp_t q[$];
  int   bp_mode = 2;

  // Monitor: choose out_ready for the coming edge, then score the output
  initial begin : mon
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      case (bp_mode)
        0:       out_ready = ($urandom_range(0, 2) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          check("unexpected out_valid", out_valid, 0);
        end else begin
          if (!pv) check("latency", 255'(cyc - q[0].t), 255'(LAT));
          check("y", y, q[0].y);
          check("in_ready in DONE", in_ready, 0);
          check("busy in DONE", busy, 1);
`ifdef OKA_REDUCE_EN
          check("y_red", 255'(y_red), 255'(q[0].r));
`endif
          if (out_ready) void'(q.pop_front());
        end
      end
      pv = rst_n && out_valid;
    end
  end

  // Call at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [127:0] av, input logic [127:0] bv);
    int t;
    logic [127:0] xa, xb;
    t = 0;
    while (!in_ready && t < 200) begin
      in_valid = ($urandom_range(0, 3) == 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    xa = 128'(av[W-1:0]);
    xb = 128'(bv[W-1:0]);
    a = xa[W-1:0];
    b = xb[W-1:0];
    in_valid = 1'b1;
    q.push_back(mk_exp(xa, xb, W, cyc));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!out_valid && t < 100) begin
      check("in_ready while busy", in_ready, 0);
      @(negedge clk);
      t++;
    end
    if (!out_valid) check("out_valid timeout", out_valid, 1);
  endtask

  localparam logic [127:0] ONES = 128'({W{1'b1}});
  localparam logic [127:0] MSB  = 128'(1) << 63;

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int SW = (g == 0) ? 16 : (g == 1) ? 64 : 128;
    localparam int SD = (g == 0) ? 2 : (g == 1) ? 32 : 16;
    localparam int SN = SW / 2 / SD;
    localparam int SLAT = 3 * SN + 2 + XL;

    logic            rst_s = 1'b0;
    logic            iv = 1'b0;
    logic            ir, ov, bs;
    logic            ordy = 1'b0;
    logic [SW-1:0]   sa = '0;
    logic [SW-1:0]   sb = '0;
    logic [2*SW-2:0] sy;
`ifdef OKA_REDUCE_EN
    logic [SW-1:0]   sr;
`endif
    bit              done = 1'b0;
    exp_t            sq[$];

    oka_gf2_mul_seq #(.WIDTH(SW), .DIGIT(SD)) u_dut (
      .clk(clk),
      .rst_n(rst_s),
      .in_valid(iv),
      .in_ready(ir),
      .a(sa),
      .b(sb),
      .out_valid(ov),
      .out_ready(ordy),
      .y(sy),
`ifdef OKA_REDUCE_EN
      .y_red(sr),
`endif
      .busy(bs)
    );

    initial begin : drv
      int t;
      logic [127:0] ra, rb;
      repeat (2) @(negedge clk);
      rst_s = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 150; k++) begin
        t = 0;
        while (!ir && t < 300) begin
          @(negedge clk);
          t++;
        end
        if (!ir) begin
          check($sformatf("cfg%0d in_ready timeout", g), ir, 1);
          break;
        end
        ra = rnd(SW);
        rb = rnd(SW);
        sa = ra[SW-1:0];
        sb = rb[SW-1:0];
        iv = 1'b1;
        sq.push_back(mk_exp(ra, rb, SW, cyc));
        @(negedge clk);
        iv = 1'b0;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      t = 0;
      while (sq.size() != 0 && t < 1000) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("cfg%0d drain", g), 255'(sq.size()), 0);
      done = 1'b1;
    end

    initial begin : smon
      logic pv;
      pv = 1'b0;
      forever begin
        @(negedge clk);
        ordy = ($urandom_range(0, 2) != 0);
        if (rst_s && ov) begin
          if (sq.size() == 0) begin
            check($sformatf("cfg%0d unexpected out_valid", g), ov, 0);
          end else begin
            if (!pv) check($sformatf("cfg%0d latency", g),
                           255'(cyc - sq[0].t), 255'(SLAT));
            check($sformatf("cfg%0d y", g), 255'(sy), sq[0].y);
            check($sformatf("cfg%0d busy", g), bs, 1);
`ifdef OKA_REDUCE_EN
            check($sformatf("cfg%0d y_red", g), 255'(sr), 255'(sq[0].r));
`endif
            if (ordy) void'(sq.pop_front());
          end
        end
        pv = rst_s && ov;
      end
    end
  end

  initial begin : main
    int t;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset y", y, 0);
`ifdef OKA_REDUCE_EN
    check("reset y_red", 255'(y_red), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    send(1, 1);
    wait_done();
    check("y 1*1", y, 255'd1);
    send(3, 3);
    wait_done();
    check("y 3*3", y, 255'd5);
    send(ONES, 1);
    wait_done();
    check("y ones*1", y, 255'(ONES));
    send(MSB, MSB);
    wait_done();
    check("y msb*msb", y, 255'(1) << 126);
    send(0, rnd(W));
    wait_done();
    send(rnd(W), 0);
    wait_done();
`ifdef OKA_REDUCE_EN
    send(MSB, 2);
    wait_done();
    check("y msb*2", y, 255'(1) << 64);
    check("y_red msb*2", 255'(y_red), 255'h1B);
`endif

    // Backpressure: held output, extra in_valid pulse must be dropped
    bp_mode = 1;
    send(rnd(W), rnd(W));
    wait_done();
    for (int i = 0; i < 10; i++) begin
      check("held out_valid", out_valid, 1);
      check("held in_ready", in_ready, 0);
      in_valid = (i == 3);
      a = 64'd5;
      b = 64'd7;
      @(negedge clk);
    end
    in_valid = 1'b0;
    bp_mode = 2;

    // Asynchronous reset in the middle of MUL_Z1
    send(rnd(W), rnd(W));
    repeat (N + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst busy", busy, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(3, 3);
    wait_done();
    check("y 3*3 after reset", y, 255'd5);

    bp_mode = 0;
    for (int k = 0; k < 600; k++) begin
      send(rnd(W), rnd(W));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    t = 0;
    while ((q.size() != 0 || !g_cfg[0].done || !g_cfg[1].done ||
            !g_cfg[2].done) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("main drain", 255'(q.size()), 0);
    check("cfg0 finished", g_cfg[0].done, 1);
    check("cfg1 finished", g_cfg[1].done, 1);
    check("cfg2 finished", g_cfg[2].done, 1);
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule
